// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  read,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int AF_LEVEL = DEPTH - AF_MARGIN;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_evt;
  logic                  udf_evt;
  int                    level_i;

  // Status flags come straight from the registered level, so they move with it.
  assign level_i      = int'(level);
  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level_i >= AF_LEVEL);
  assign almost_empty = (level_i <= AE_MARGIN);

  assign wr_ok   = write & (~full | read);
  assign rd_ok   = read & ~empty;
  assign ovf_evt = write & ~wr_ok & ~flush;
  assign udf_evt = read & ~rd_ok & ~flush;

  always_ff @(posedge CLK) begin
    if (!RESET && !flush && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A new error event beats clear_err in the same cycle.
      overflow  <= (overflow & ~clear_err) | ovf_evt;
      underflow <= (underflow & ~clear_err) | udf_evt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_ok) begin
          data_out <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
          level <= level + 1'b1;
        end else if (rd_ok && !wr_ok) begin
          level <= level - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a queue-based reference model predicts every cycle's
// outputs, which a separate monitor compares against the DUT.
module tb_param_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int AEM   = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] data_in;
  logic          write;
  logic          read;
  logic          flush;
  logic          clear_err;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  param_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .data_in     (data_in),
    .write       (write),
    .read        (read),
    .flush       (flush),
    .clear_err   (clear_err),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] dout;
    int            lvl;
    logic          ovf;
    logic          udf;
  } snap_t;

  snap_t         exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;
  int            compared   = 0;
  int            mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model and queue its prediction.
  task automatic applyStimulus(input logic rst, input logic w, input logic r,
                               input logic fl, input logic ce, input logic [DW-1:0] d);
    logic  wok, rok;
    snap_t s;
    RESET = rst; write = w; read = r; flush = fl; clear_err = ce; data_in = d;
    if (rst) begin
      model_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (fl) begin
      model_q.delete();
      if (ce) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
    end else begin
      wok = w && (model_q.size() < DEPTH || r);
      rok = r && model_q.size() > 0;
      if (rok) m_dout = model_q.pop_front();
      if (wok) model_q.push_back(d);
      m_ovf = (m_ovf && !ce) || (w && !wok);
      m_udf = (m_udf && !ce) || (r && !rok);
    end
    s.dout = m_dout;
    s.lvl  = model_q.size();
    s.ovf  = m_ovf;
    s.udf  = m_udf;
    exp_q.push_back(s);
    @(negedge CLK);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic rd();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  // Monitor: one prediction per clock edge, sampled just after the edge.
  initial begin
    snap_t s;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        checkOutput("data_out",     64'(data_out),     64'(s.dout));
        checkOutput("level",        64'(level),        64'(s.lvl));
        checkOutput("full",         64'(full),         64'(s.lvl == DEPTH));
        checkOutput("empty",        64'(empty),        64'(s.lvl == 0));
        checkOutput("almost_full",  64'(almost_full),  64'(s.lvl >= DEPTH - AFM));
        checkOutput("almost_empty", 64'(almost_empty), 64'(s.lvl <= AEM));
        checkOutput("overflow",     64'(overflow),     64'(s.ovf));
        checkOutput("underflow",    64'(underflow),    64'(s.udf));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int wp, rp, fp, cp;
    RESET = 1'b1; write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0; data_in = '0;
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle();

    $display("[TB] reset and fill");
    for (int i = 1; i <= 16; i++) wr(DW'(i));

    $display("[TB] overflow and drain");
    wr(32'hDEADBEEF);
    for (int i = 0; i < 16; i++) rd();
    idle();

    $display("[TB] underflow and empty corner");
    rd();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
    rd();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);

    $display("[TB] full simultaneous read/write with wrap");
    for (int i = 1; i <= 16; i++) wr(DW'(i));
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DW'(32'h100 + i));
    for (int i = 0; i < 16; i++) rd();

    $display("[TB] flush versus traffic");
    for (int i = 0; i < 7; i++) wr(DW'(32'h700 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hBAD0BAD0);
    idle();
    wr(32'h0000C0DE);
    rd();

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 17; i++) wr(DW'(32'h900 + i));
    for (int i = 0; i < 7; i++) rd();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5555AAAA);
    idle();
    wr(32'h12345678);
    rd();
    idle();

    $display("[TB] randomized traffic");
    for (int ph = 0; ph < 6; ph++) begin
      wp = (ph % 2 == 0) ? 80 : 30;
      rp = (ph % 2 == 0) ? 30 : 80;
      fp = (ph == 4) ? 5 : 1;
      cp = 5;
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) < wp,
                      $urandom_range(0, 99) < rp,
                      $urandom_range(0, 99) < fp,
                      $urandom_range(0, 99) < cp,
                      DW'($urandom));
      end
    end
    idle();
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
